wb_writer: RTL and testbench
============================

Name: wb_writer

Overview:
- Write-back stage of the pipeline and sole driver of the register file write port (wdata, waddr, RegWrite_MW).
- Captures the M-stage result at each edge and aligns/sign-extends load data.
- Selects among ALU, load, PC+4 and CSR data.
- Arbitrates between in-order pipeline writes and a late-result writer (divider/multi-cycle unit) through a one-entry skid buffer.
- Exports the buffered destination so the hazard unit can stall dependent reads.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_m  in  1  M-stage instruction valid.
- regwrite_m  in  1  M-stage instruction writes rd.
- rd_m  in  AW  M-stage destination.
- wb_sel_m  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 CSR.
- funct3_m  in  3  load size/sign.
- alu_m  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- pc4_m  in  XLEN  PC+4.
- csr_rdata_m  in  XLEN  CSR read data.
- mem_rdata  in  XLEN  raw data-memory word.
- stall_mw  in  1  hold M stage; no pipeline write is issued this edge.
- flush_mw  in  1  kill M-stage instruction.
- lw_valid  in  1  late result offered.
- lw_rd  in  AW  late destination.
- lw_data  in  XLEN  late data.
- lw_ready  out  1  late result accepted this edge.
- wdata  out  XLEN  register file write data (registered).
- waddr  out  AW  register file write address (registered).
- RegWrite_MW  out  1  register file write enable (registered).
- pend_valid  out  1  skid buffer occupied.
- pend_rd  out  AW  destination held in the skid buffer.

Behaviour:
- Reset (async, rst=1):
  - wdata=0, waddr=0, RegWrite_MW=0.
  - Buffer empty: pend_valid=0, pend_rd=0.
  - lw_ready=1 once buffer is empty.
- Pipeline write request: pw = valid_m & regwrite_m & (rd_m!=0) & ~stall_mw & ~flush_mw.
- Data select, combinational, in the M stage: ALU / aligned load / PC+4 / CSR per wb_sel_m.
- Load alignment, by funct3_m:
  - 000 LB: byte alu_m[1:0], sign-extended.
  - 100 LBU: byte alu_m[1:0], zero-extended.
  - 001 LH: half alu_m[1], sign-extended.
  - 101 LHU: half alu_m[1], zero-extended.
  - 010 LW: full word.
  - Other funct3 codes: full word.
  - Misalignment is not checked; alu_m[0] is ignored for halfwords.
- Latency: one cycle. The write is presented on the outputs the cycle after the capture edge; the register file commits it on the following edge.
- lw_ready = ~pend_valid (combinational). A late result is accepted when lw_valid & lw_ready.
- Output slot priority at each edge, exactly one winner:
  1. pw: outputs load the M-stage write. An accepted late result in the same edge goes to the buffer.
  2. Buffer occupied (no pw): outputs load the buffer; buffer empties.
  3. Late result accepted, buffer empty (no pw): outputs load lw directly, bypassing the buffer.
  4. Nothing: RegWrite_MW=0; wdata/waddr hold their last values.
- Buffer drain and accept in the same edge cannot occur, because lw_ready=0 while the buffer is occupied.
- lw_rd=0: accepted and consumes a slot, but RegWrite_MW=0 for that slot.
- Stall and flush:
  - Stalled or flushed M instructions produce a bubble.
  - Flush has no effect on the buffer or on late results.
- Hazard contract: the hazard unit must stall reads of pend_rd while pend_valid=1, and prevent WAW between a pipeline write and a buffered late write to the same rd. The block does not reorder.
- Reset mid-operation: any buffered result is discarded; the outputs' write enable drops immediately (async).

Decomposition:
- Shared package wb_pkg:
  - wb_sel_e enum (WB_ALU, WB_MEM, WB_PC4, WB_CSR).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN/AW defaults.
- Sub-module load_align: purely combinational; inputs mem_rdata, funct3, byte offset; output aligned XLEN word.
- wb_writer holds the select mux, the output register, the skid buffer and the arbitration.

Test Plan:
- Load alignment: mem_rdata=0x8765_43F1, wb_sel=01, pw=1, rd=5. Required wdata one cycle later:
  - LB, off 0: 0xFFFF_FFF1.
  - LBU, off 0: 0x0000_00F1.
  - LH, off 2: 0xFFFF_8765.
  - LHU, off 2: 0x0000_8765.
  - LW: 0x8765_43F1.
  - In every case waddr=5 and RegWrite_MW=1.
- Source select: alu=0x10, pc4=0x104, csr=0xABCD, rd=7. wb_sel 00/10/11 -> wdata 0x10 / 0x104 / 0xABCD, waddr=7.
- x0 and bubbles: rd_m=0, stall_mw=1, or flush_mw=1 with a valid write -> RegWrite_MW=0 next cycle.
- Collision: pw (rd=3, 0x11) and lw (rd=9, 0x22) in the same edge. Required:
  - Cycle+1: write x3=0x11; pend_valid=1, pend_rd=9, lw_ready=0.
  - Cycle+2, with no pw: write x9=0x22; pend_valid=0.
- Back-pressure: buffer occupied plus continuous pw for 3 edges -> lw_ready stays 0, buffer holds, pipeline writes x1/x2/x3 in order. pw then drops -> buffered write issues the next cycle.
- Async reset: assert rst mid-cycle while buffer is full and RegWrite_MW=1 -> RegWrite_MW=0 and pend_valid=0 immediately, without waiting for a clock edge. After release, lw_ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned AW_DEF   = 5;

   // Write-back source select.
   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_CSR = 2'b11
   } wb_sel_e;

   // Load size/sign encodings (funct3).
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword of a loaded word.
// Misalignment is not checked: off_i[0] is ignored for halfwords.
module load_align
   import wb_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      off_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the byte/half lane selected by the address offset, then extend.
   always_comb begin
      byte_sel = mem_rdata_i[{off_i, 3'b000} +: 8];
      half_sel = mem_rdata_i[{off_i[1], 4'b0000} +: 16];
      unique case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
         default: data_o = mem_rdata_i;
      endcase
   end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: selects the M-stage result, arbitrates it against a
// late-result writer through a one-entry skid buffer, and registers the
// register-file write port.
module wb_writer
   import wb_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = AW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_m,
   input  logic            regwrite_m,
   input  logic [AW-1:0]   rd_m,
   input  logic [1:0]      wb_sel_m,
   input  logic [2:0]      funct3_m,
   input  logic [XLEN-1:0] alu_m,
   input  logic [XLEN-1:0] pc4_m,
   input  logic [XLEN-1:0] csr_rdata_m,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            stall_mw,
   input  logic            flush_mw,
   input  logic            lw_valid,
   input  logic [AW-1:0]   lw_rd,
   input  logic [XLEN-1:0] lw_data,
   output logic            lw_ready,
   output logic [XLEN-1:0] wdata,
   output logic [AW-1:0]   waddr,
   output logic            RegWrite_MW,
   output logic            pend_valid,
   output logic [AW-1:0]   pend_rd
);

   logic            pw;
   logic            lw_acc;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] m_data;

   logic [XLEN-1:0] wdata_d, wdata_q;
   logic [AW-1:0]   waddr_d, waddr_q;
   logic            we_d, we_q;
   logic            pend_valid_d, pend_valid_q;
   logic [AW-1:0]   pend_rd_d, pend_rd_q;
   logic [XLEN-1:0] pend_data_d, pend_data_q;

   load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .mem_rdata_i (mem_rdata),
      .funct3_i    (funct3_m),
      .off_i       (alu_m[1:0]),
      .data_o      (load_data)
   );

   // Writes to x0 never request the port.
   assign pw       = valid_m & regwrite_m & (rd_m != '0) & ~stall_mw & ~flush_mw;
   // The buffer is never drained and refilled on the same edge.
   assign lw_ready = ~pend_valid_q;
   assign lw_acc   = lw_valid & lw_ready;

   // M-stage source select.
   always_comb begin
      unique case (wb_sel_e'(wb_sel_m))
         WB_ALU:  m_data = alu_m;
         WB_MEM:  m_data = load_data;
         WB_PC4:  m_data = pc4_m;
         WB_CSR:  m_data = csr_rdata_m;
         default: m_data = alu_m;
      endcase
   end

   // Output slot arbitration: pipeline, then buffer, then direct late result.
   always_comb begin
      wdata_d      = wdata_q;
      waddr_d      = waddr_q;
      we_d         = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_rd_d    = pend_rd_q;
      pend_data_d  = pend_data_q;
      if (pw) begin
         wdata_d = m_data;
         waddr_d = rd_m;
         we_d    = 1'b1;
         if (lw_acc) begin
            pend_valid_d = 1'b1;
            pend_rd_d    = lw_rd;
            pend_data_d  = lw_data;
         end
      end else if (pend_valid_q) begin
         wdata_d      = pend_data_q;
         waddr_d      = pend_rd_q;
         we_d         = (pend_rd_q != '0);
         pend_valid_d = 1'b0;
      end else if (lw_acc) begin
         wdata_d = lw_data;
         waddr_d = lw_rd;
         we_d    = (lw_rd != '0);
      end
   end

   // Output register and skid buffer state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdata_q      <= '0;
         waddr_q      <= '0;
         we_q         <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_rd_q    <= '0;
         pend_data_q  <= '0;
      end else begin
         wdata_q      <= wdata_d;
         waddr_q      <= waddr_d;
         we_q         <= we_d;
         pend_valid_q <= pend_valid_d;
         pend_rd_q    <= pend_rd_d;
         pend_data_q  <= pend_data_d;
      end
   end

   assign wdata       = wdata_q;
   assign waddr       = waddr_q;
   assign RegWrite_MW = we_q;
   assign pend_valid  = pend_valid_q;
   assign pend_rd     = pend_rd_q;

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: a driver computes the expected write-port
// state from a queue-based reference model, a monitor compares after each edge.
module tb_wb_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_m = 1'b0, regwrite_m = 1'b0;
   logic [4:0]  rd_m = '0;
   logic [1:0]  wb_sel_m = '0;
   logic [2:0]  funct3_m = '0;
   logic [31:0] alu_m = '0, pc4_m = '0, csr_rdata_m = '0, mem_rdata = '0;
   logic        stall_mw = 1'b0, flush_mw = 1'b0;
   logic        lw_valid = 1'b0;
   logic [4:0]  lw_rd = '0;
   logic [31:0] lw_data = '0;
   logic        lw_ready;
   logic [31:0] wdata;
   logic [4:0]  waddr;
   logic        RegWrite_MW;
   logic        pend_valid;
   logic [4:0]  pend_rd;

   wb_writer dut (
      .clk         (clk),
      .rst         (rst),
      .valid_m     (valid_m),
      .regwrite_m  (regwrite_m),
      .rd_m        (rd_m),
      .wb_sel_m    (wb_sel_m),
      .funct3_m    (funct3_m),
      .alu_m       (alu_m),
      .pc4_m       (pc4_m),
      .csr_rdata_m (csr_rdata_m),
      .mem_rdata   (mem_rdata),
      .stall_mw    (stall_mw),
      .flush_mw    (flush_mw),
      .lw_valid    (lw_valid),
      .lw_rd       (lw_rd),
      .lw_data     (lw_data),
      .lw_ready    (lw_ready),
      .wdata       (wdata),
      .waddr       (waddr),
      .RegWrite_MW (RegWrite_MW),
      .pend_valid  (pend_valid),
      .pend_rd     (pend_rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, rw;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [31:0] alu, pc4, csr, mem;
      logic        st, fl, lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
   } stim_t;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        pv;
      logic [4:0]  prd;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } late_t;

   exp_t  sb[$];
   late_t lq[$];     // model of the skid buffer (capacity one)
   int    n_chk  = 0;
   int    n_pass = 0;
   bit    mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Load extraction from the RISC-V load rules, by shifting and masking.
   function automatic logic [31:0] ref_load(input logic [31:0] m, input logic [2:0] f3,
                                            input logic [1:0] off);
      int unsigned b, h;
      b = (m >> (8 * off)) & 32'hFF;
      h = (m >> (16 * off[1])) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'b101:  return h;
         default: return m;
      endcase
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{v: 0, rw: 0, rd: 0, sel: 0, f3: 0, alu: 0, pc4: 0, csr: 0, mem: 0,
            st: 0, fl: 0, lv: 0, lrd: 0, ld: 0};
      return s;
   endfunction

   // Drive one cycle of inputs and push the expected post-edge state.
   task automatic step(input stim_t s);
      exp_t  e;
      late_t l;
      bit    pw, acc;
      logic [31:0] md;
      @(negedge clk);
      valid_m = s.v; regwrite_m = s.rw; rd_m = s.rd; wb_sel_m = s.sel; funct3_m = s.f3;
      alu_m = s.alu; pc4_m = s.pc4; csr_rdata_m = s.csr; mem_rdata = s.mem;
      stall_mw = s.st; flush_mw = s.fl; lw_valid = s.lv; lw_rd = s.lrd; lw_data = s.ld;
      pw  = s.v && s.rw && (s.rd != 0) && !s.st && !s.fl;
      acc = s.lv && (lq.size() == 0);
      case (s.sel)
         2'd0:    md = s.alu;
         2'd1:    md = ref_load(s.mem, s.f3, s.alu[1:0]);
         2'd2:    md = s.pc4;
         default: md = s.csr;
      endcase
      e = '{we: 0, addr: 0, data: 0, pv: 0, prd: 0};
      if (pw) begin
         e.we = 1; e.addr = s.rd; e.data = md;
         if (acc) lq.push_back('{rd: s.lrd, data: s.ld});
      end else if (lq.size() != 0) begin
         l = lq.pop_front();
         e.we = (l.rd != 0); e.addr = l.rd; e.data = l.data;
      end else if (acc) begin
         e.we = (s.lrd != 0); e.addr = s.lrd; e.data = s.ld;
      end
      e.pv = (lq.size() != 0);
      if (e.pv) e.prd = lq[0].rd;
      sb.push_back(e);
   endtask

   // Monitor: compare the registered write port after each active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (mon_en && sb.size() != 0) begin
         e = sb.pop_front();
         chk("RegWrite_MW", {31'b0, RegWrite_MW}, {31'b0, e.we});
         if (e.we) begin
            chk("waddr", {27'b0, waddr}, {27'b0, e.addr});
            chk("wdata", wdata, e.data);
         end
         chk("pend_valid", {31'b0, pend_valid}, {31'b0, e.pv});
         if (e.pv) chk("pend_rd", {27'b0, pend_rd}, {27'b0, e.prd});
         chk("lw_ready", {31'b0, lw_ready}, {31'b0, !e.pv});
      end
   end

   initial begin
      stim_t s;
      logic [2:0]  f3_tab[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  off_tab[5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
      logic [1:0]  sel_tab[3] = '{2'd0, 2'd2, 2'd3};

      // Reset state.
      #2;
      chk("reset RegWrite_MW", {31'b0, RegWrite_MW}, 32'd0);
      chk("reset wdata", wdata, 32'd0);
      chk("reset waddr", {27'b0, waddr}, 32'd0);
      chk("reset pend_valid", {31'b0, pend_valid}, 32'd0);
      chk("reset pend_rd", {27'b0, pend_rd}, 32'd0);
      chk("reset lw_ready", {31'b0, lw_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // Load alignment.
      for (int i = 0; i < 5; i++) begin
         s = idle();
         s.v = 1; s.rw = 1; s.rd = 5; s.sel = 2'd1; s.f3 = f3_tab[i];
         s.alu = {30'h100, off_tab[i]}; s.mem = 32'h8765_43F1;
         step(s);
      end

      // Source select.
      for (int i = 0; i < 3; i++) begin
         s = idle();
         s.v = 1; s.rw = 1; s.rd = 7; s.sel = sel_tab[i];
         s.alu = 32'h10; s.pc4 = 32'h104; s.csr = 32'hABCD;
         step(s);
      end

      // x0, stall, flush bubbles.
      for (int i = 0; i < 3; i++) begin
         s = idle();
         s.v = 1; s.rw = 1; s.rd = (i == 0) ? 5'd0 : 5'd4; s.alu = 32'h55;
         s.st = (i == 1); s.fl = (i == 2);
         step(s);
      end

      // Collision, then back-pressure with continuous pipeline writes.
      s = idle();
      s.v = 1; s.rw = 1; s.rd = 3; s.alu = 32'h11; s.lv = 1; s.lrd = 9; s.ld = 32'h22;
      step(s);
      for (int i = 1; i <= 3; i++) begin
         s = idle();
         s.v = 1; s.rw = 1; s.rd = 5'(i); s.alu = 32'(i * 16);
         s.lv = 1; s.lrd = 20; s.ld = 32'hDEAD;
         step(s);
      end
      step(idle());
      step(idle());

      // Late write to x0 consumes a slot without writing.
      s = idle();
      s.lv = 1; s.lrd = 0; s.ld = 32'h77;
      step(s);
      step(idle());

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         s.v   = ($urandom_range(0, 3) != 0);
         s.rw  = ($urandom_range(0, 3) != 0);
         s.rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         s.sel = 2'($urandom);
         s.f3  = 3'($urandom);
         s.alu = $urandom; s.pc4 = $urandom; s.csr = $urandom; s.mem = $urandom;
         s.st  = ($urandom_range(0, 7) == 0);
         s.fl  = ($urandom_range(0, 7) == 0);
         s.lv  = ($urandom_range(0, 1) == 1);
         s.lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         s.ld  = $urandom;
         step(s);
      end
      step(idle());
      step(idle());

      // Async reset with the buffer full and a write on the port.
      s = idle();
      s.v = 1; s.rw = 1; s.rd = 12; s.alu = 32'h1234; s.lv = 1; s.lrd = 13; s.ld = 32'h5678;
      step(s);
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      valid_m = 0; regwrite_m = 0; lw_valid = 0;
      rst = 1'b1;
      lq.delete();
      #1;
      chk("async RegWrite_MW", {31'b0, RegWrite_MW}, 32'd0);
      chk("async pend_valid", {31'b0, pend_valid}, 32'd0);
      chk("async lw_ready", {31'b0, lw_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-reset lw_ready", {31'b0, lw_ready}, 32'd1);
      mon_en = 1'b1;
      s = idle();
      s.lv = 1; s.lrd = 2; s.ld = 32'hCAFE;
      step(s);
      step(idle());

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
      #2;
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
